sata_link_read_fifo: RTL
========================

Name: sata_link_read_fifo

Overview:
- Receive frame buffer directly downstream of the link-layer read path.
- Captures per-dword strobes from the link reader into a circular dword RAM and drives the link's read_ready flow control.
- At end of frame, samples the link's CRC verdict and either commits the frame to the transport layer or rewinds and discards it.
- Presents committed frames on a valid/ready stream with first/last markers and length.

Parameters:
- ADDR_WIDTH, 6, log2 of buffer depth in dwords (default 64).
- HOLD_THRESHOLD, 20, minimum free dwords needed to keep read_ready high during a frame; covers remote HOLD latency.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- read_start  in  1  link SOF pulse
- read_strobe  in  1  link data dword valid
- read_data  in  32  link data dword
- read_finished  in  1  link EOF pulse
- crc_ok  in  1  link CRC verdict, valid the cycle after read_finished
- remote_abort  in  1  link abort pulse (SYNC mid-frame)
- read_ready  out  1  buffer can accept/continue a frame
- fis_valid  out  1  output dword valid
- fis_data  out  32  output dword
- fis_first  out  1  first dword of frame, qualified by fis_valid
- fis_last  out  1  last dword of frame, qualified by fis_valid
- fis_len  out  ADDR_WIDTH+1  dword count of the pending frame; held while frame_avail
- fis_ready  in  1  consumer accepts dword
- frame_avail  out  1  a committed frame is pending or draining
- crc_error  out  1  one-cycle pulse: frame discarded on bad CRC or overflow
- abort_seen  out  1  one-cycle pulse: frame discarded on remote_abort
- good_frames, bad_frames  out  16 each  statistics counters (see Optional Feature)

Behaviour:
- Reset (rst low, async) values: all outputs 0, pointers 0, write FSM in IDLE, overflow flag cleared.
- Pointers are wr_ptr, frm_start, rd_ptr, each ADDR_WIDTH+1 bits with a wrap bit.
- used = wr_ptr - rd_ptr; free = 2^ADDR_WIDTH - used.
- Write FSM states: IDLE, RECV, CHECK.
  - IDLE, read_start: frm_start <= wr_ptr, clear overflow, go to RECV.
  - RECV, read_strobe: if used < depth, write RAM[wr_ptr] and increment wr_ptr; otherwise drop the word and set overflow.
  - RECV, remote_abort: wr_ptr <= frm_start, pulse abort_seen, go to IDLE.
  - RECV, read_finished: go to CHECK. A strobe in the same cycle is written first.
  - CHECK (exactly 1 cycle): sample crc_ok. If crc_ok && !overflow && length>0, commit (fis_len <= wr_ptr-frm_start, frame_avail <= 1). If crc_ok && !overflow && length==0, discard silently. If !crc_ok or overflow, wr_ptr <= frm_start and pulse crc_error. In every case go to IDLE.
  - read_start while in RECV: restart, i.e. rewind wr_ptr to frm_start and then begin a new frame.
- read_ready (registered):
  - IDLE: 1 iff !frame_avail. Only one committed frame is held; the link withholds R_RDY until it drains.
  - RECV: 1 iff free > HOLD_THRESHOLD.
  - CHECK: 0.
- Read side:
  - Read path is first-word-fall-through; fis_data is registered from RAM[rd_ptr].
  - fis_valid asserts at most 2 cycles after frame_avail rises.
  - A transfer occurs on fis_valid && fis_ready, and increments rd_ptr and a beat counter.
  - fis_first = (beat==0); fis_last = (beat==fis_len-1).
  - On the last transfer, frame_avail <= 0 and the beat counter clears.
  - fis_valid never asserts beyond the committed region.
- Wrap-around: pointers wrap modulo 2^(ADDR_WIDTH+1), so frames may straddle the RAM end.
- Full (used == depth) and empty (used == 0) are distinguished by the wrap bit.

Optional Feature:
- Macro: SATA_READ_FIFO_STATS_EN.
- Defined:
  - good_frames increments on each commit.
  - bad_frames increments on each crc_error or abort_seen pulse.
  - Both counters are 16-bit, saturating at 16'hFFFF, and reset to 0.
- Undefined: both outputs tied to 0 and no counter logic is inferred.

Test Plan:
- SOF, 8 strobes (data 0x1..0x8), EOF, crc_ok=1 -> frame_avail=1, fis_len=8; with fis_ready=1, output 0x1..0x8, first on 0x1, last on 0x8; read_ready returns to 1 after drain.
- Same frame with crc_ok=0 -> crc_error pulses once, frame_avail stays 0, wr_ptr equals its pre-frame value, next good frame is delivered intact.
- SOF, 5 strobes, remote_abort -> abort_seen pulse, no frame delivered, bad_frames=1 with SATA_READ_FIFO_STATS_EN.
- ADDR_WIDTH=6, 50-dword frame with fis_ready=0 on a prior frame -> read_ready drops when free <= 20; 70 strobes -> overflow, crc_error at CHECK even with crc_ok=1.
- Pointers preset near end (60 dwords written and drained), then 10-dword good frame -> data is correct across the RAM wrap.
- rst asserted mid-RECV -> all outputs 0 immediately, frame lost, next frame after rst release is delivered normally.

Source files
------------

// File: rtl/sata_link_read_fifo.sv
// Receive frame buffer behind the SATA link read path: stores dwords, commits or discards frames
// on the CRC verdict, and streams committed frames out. Optional counters: SATA_READ_FIFO_STATS_EN.
module sata_link_read_fifo #(
   parameter int unsigned ADDR_WIDTH     = 6,
   parameter int unsigned HOLD_THRESHOLD = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read_start,
   input  logic                  read_strobe,
   input  logic [31:0]           read_data,
   input  logic                  read_finished,
   input  logic                  crc_ok,
   input  logic                  remote_abort,
   output logic                  read_ready,
   output logic                  fis_valid,
   output logic [31:0]           fis_data,
   output logic                  fis_first,
   output logic                  fis_last,
   output logic [ADDR_WIDTH:0]   fis_len,
   input  logic                  fis_ready,
   output logic                  frame_avail,
   output logic                  crc_error,
   output logic                  abort_seen,
   output logic [15:0]           good_frames,
   output logic [15:0]           bad_frames
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] HOLD_W  = (ADDR_WIDTH + 1)'(HOLD_THRESHOLD);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RECV  = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;

   logic [31:0]         ram [DEPTH];
   logic [1:0]          state, state_d;
   logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_d;
   logic [ADDR_WIDTH:0] frm_start, frm_start_d;
   logic [ADDR_WIDTH:0] rd_ptr, rd_ptr_d;
   logic [ADDR_WIDTH:0] beat, beat_d;
   logic [ADDR_WIDTH:0] fis_len_d;
   logic [ADDR_WIDTH:0] used, frm_len, free_d;
   logic                overflow, overflow_d;
   logic                ram_we, commit, xfer, last_beat, slot_busy;
   logic                frame_avail_d, fis_valid_d, read_ready_d;
   logic                crc_error_d, abort_seen_d;
   logic [31:0]         fis_data_d;

   assign used      = wr_ptr - rd_ptr;
   assign frm_len   = wr_ptr - frm_start;
   assign xfer      = fis_valid & fis_ready;
   assign last_beat = (beat == fis_len - PTR_ONE);
   assign fis_first = fis_valid & (beat == '0);
   assign fis_last  = fis_valid & last_beat;
   // Holding slot stays occupied unless its final beat leaves this cycle.
   assign slot_busy = frame_avail & ~(xfer & last_beat);

   always_comb begin
      state_d      = state;
      wr_ptr_d     = wr_ptr;
      frm_start_d  = frm_start;
      overflow_d   = overflow;
      ram_we       = 1'b0;
      commit       = 1'b0;
      crc_error_d  = 1'b0;
      abort_seen_d = 1'b0;
      case (state)
         IDLE: begin
            if (read_start) begin
               frm_start_d = wr_ptr;
               overflow_d  = 1'b0;
               state_d     = RECV;
            end
         end
         RECV: begin
            if (remote_abort) begin
               wr_ptr_d     = frm_start;
               abort_seen_d = 1'b1;
               state_d      = IDLE;
            end else if (read_start) begin
               wr_ptr_d   = frm_start;
               overflow_d = 1'b0;
            end else begin
               if (read_strobe) begin
                  if (used < DEPTH_W) begin
                     ram_we   = 1'b1;
                     wr_ptr_d = wr_ptr + PTR_ONE;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
               if (read_finished) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            state_d = IDLE;
            if (!crc_ok || overflow) begin
               wr_ptr_d    = frm_start;
               crc_error_d = 1'b1;
            end else if (frm_len != '0) begin
               if (slot_busy) begin
                  // Link ignored read_ready; only one committed frame can be held.
                  wr_ptr_d    = frm_start;
                  crc_error_d = 1'b1;
               end else begin
                  commit = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_ptr_d      = rd_ptr;
      beat_d        = beat;
      frame_avail_d = frame_avail;
      fis_len_d     = fis_len;
      fis_data_d    = fis_data;
      if (xfer) begin
         rd_ptr_d = rd_ptr + PTR_ONE;
         if (last_beat) begin
            beat_d        = '0;
            frame_avail_d = 1'b0;
         end else begin
            beat_d = beat + PTR_ONE;
         end
      end
      if (commit) begin
         frame_avail_d = 1'b1;
         fis_len_d     = frm_len;
      end
      fis_valid_d = frame_avail & ~(xfer & last_beat);
      if (fis_valid_d) begin
         fis_data_d = ram[rd_ptr_d[ADDR_WIDTH-1:0]];
      end
      free_d = DEPTH_W - (wr_ptr_d - rd_ptr_d);
      case (state_d)
         IDLE:    read_ready_d = ~frame_avail_d;
         RECV:    read_ready_d = (free_d > HOLD_W);
         default: read_ready_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[wr_ptr[ADDR_WIDTH-1:0]] <= read_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         frm_start   <= '0;
         rd_ptr      <= '0;
         beat        <= '0;
         overflow    <= 1'b0;
         read_ready  <= 1'b0;
         fis_valid   <= 1'b0;
         fis_data    <= '0;
         fis_len     <= '0;
         frame_avail <= 1'b0;
         crc_error   <= 1'b0;
         abort_seen  <= 1'b0;
      end else begin
         state       <= state_d;
         wr_ptr      <= wr_ptr_d;
         frm_start   <= frm_start_d;
         rd_ptr      <= rd_ptr_d;
         beat        <= beat_d;
         overflow    <= overflow_d;
         read_ready  <= read_ready_d;
         fis_valid   <= fis_valid_d;
         fis_data    <= fis_data_d;
         fis_len     <= fis_len_d;
         frame_avail <= frame_avail_d;
         crc_error   <= crc_error_d;
         abort_seen  <= abort_seen_d;
      end
   end

`ifdef SATA_READ_FIFO_STATS_EN
   logic [15:0] good_cnt, bad_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         if (commit && good_cnt != 16'hFFFF) begin
            good_cnt <= good_cnt + 16'd1;
         end
         if ((crc_error_d || abort_seen_d) && bad_cnt != 16'hFFFF) begin
            bad_cnt <= bad_cnt + 16'd1;
         end
      end
   end

   assign good_frames = good_cnt;
   assign bad_frames  = bad_cnt;
`else
   assign good_frames = '0;
   assign bad_frames  = '0;
`endif

endmodule
